hrange_arbiter: RTL and testbench
=================================

HRANGE_ARBITER -- requirements
Module: hrange_arbiter

Interface
REQ-001 Parameter: W, default 32, signed width of n and output data.
REQ-002 Port: _clock  input  1  single clock; all state changes on rising edge.
REQ-003 Port: _reset  input  1  reset, asynchronous, active-high.
REQ-004 Port: req0_start, req1_start  input  1 each  one-cycle request pulse from requester k.
REQ-005 Port: req0_n, req1_n  input  W signed each  argument n; sampled only in the cycle reqk_start is high.
REQ-006 Port: req0_ready, req1_ready  input  1 each  requester k can accept an output item.
REQ-007 Port: req0_valid, req1_valid  output  1 each  shared output bus holds a valid item for requester k.
REQ-008 Port: req0_done, req1_done  output  1 each  one-cycle pulse when requester k's sequence completes.
REQ-009 Port: req0_busy, req1_busy  output  1 each  requester k is pending or granted.
REQ-010 Port: out0, out1  output  W signed each  shared output data bus.
REQ-011 Port: gen_start  output  1  start pulse to the shared generator.
REQ-012 Port: gen_n  output  W signed  argument to the generator.
REQ-013 Port: gen_ready  output  1  ready to the generator.
REQ-014 Port: gen_valid, gen_done  input  1 each  generator valid and done-pulse.
REQ-015 Port: gen_out0, gen_out1  input  W signed each  generator output tuple.

Function
REQ-016 The block SHALL time-share one ready/valid generator between two requesters.
- States: IDLE, LAUNCH, STREAM.
- Registers: pending0/1, n0/n1, grant (1 bit), last (1 bit).
REQ-017 When reqk_start is high, pendingk SHALL be 0 and requester k SHALL not be granted.
- On that edge: pendingk <= 1, nk <= reqk_n.
- Otherwise the start pulse SHALL be silently ignored; nk is left unchanged.
REQ-018 In IDLE with exactly one pendingk set:
- grant <= k, pendingk <= 0, next state LAUNCH.
REQ-019 In IDLE with both pending:
- grant <= !last (round-robin).
- Clear that requester's pending flag; next state LAUNCH.
REQ-020 In LAUNCH:
- gen_start SHALL be 1 and gen_n SHALL equal n[grant], for exactly one cycle.
- Next state STREAM.
REQ-021 gen_start SHALL be 0 outside LAUNCH; gen_n SHALL hold n[grant] in all states.
REQ-022 In STREAM, combinationally:
- out0/out1 = gen_out0/gen_out1.
- req[grant]_valid = gen_valid.
- gen_ready = req[grant]_ready.
- req[grant]_done = gen_done.
REQ-023 Outside STREAM, all reqk_valid, reqk_done and gen_ready SHALL be 0; the non-granted requester's valid/done SHALL always be 0.
REQ-024 In STREAM with gen_done high: last <= grant, next state IDLE.
REQ-025 Latency: reqk_start at edge t, with the arbiter in IDLE and no competitor pending:
- LAUNCH during cycle t+2 (gen_start high).
- STREAM from t+3.
REQ-026 reqk_busy SHALL be pendingk OR (state != IDLE AND grant == k).
REQ-027 Zero-length sequences (n <= 0) SHALL follow the same path: no valid items, a single reqk_done pulse, return to IDLE.
REQ-028 A start from the other requester during LAUNCH or STREAM SHALL be queued as pending and served on the next IDLE visit.
REQ-029 Back-to-back service: after gen_done, the queued requester SHALL enter LAUNCH exactly 2 cycles after the done edge (IDLE, then LAUNCH).

Reset
REQ-030 Asserting _reset SHALL immediately, without a clock edge, set:
- state = IDLE, pending0/1 = 0, grant = 0, last = 1, n0/n1 = 0.
REQ-031 While in reset, outputs SHALL read gen_start = 0, gen_ready = 0, all reqk_valid/done/busy = 0, and out0/out1 following gen_out0/gen_out1.
REQ-032 Reset mid-STREAM SHALL abandon the sequence with no reqk_done pulse; the generator shares _reset externally.
REQ-033 After reset release, req0 SHALL win the first simultaneous contention (last = 1).

Verification
REQ-034 Single request: req0_start with req0_n = 3, req0_ready held 1 -> gen_start at t+2, req0 receives (0,0),(1,1),(2,2), one req0_done pulse, req0_busy falls after done.
REQ-035 Simultaneous: req0_start (n = 2) and req1_start (n = 1) on the same edge -> req0 served first, then req1 gets (0,0); req1 LAUNCH 2 cycles after req0 done.
REQ-036 Fairness: repeat simultaneous requests three times -> grant order 0,1,0,1,0,1; req1_valid is never high while req0 is granted.
REQ-037 Backpressure: n = 4, req0_ready toggles 1,0,1,0 -> gen_ready mirrors req0_ready, items 0..3 are delivered once each in order, none lost or duplicated.
REQ-038 Edge cases: n = 0 -> zero valid cycles and one done pulse; a duplicate req0_start while busy -> ignored, exactly one sequence delivered.
REQ-039 Async reset: _reset asserted mid-STREAM between clock edges -> outputs at reset values before the next edge, no done pulse, next request served normally.

Source files
------------

// File: rtl/hrange_arbiter.sv
// hrange_arbiter: shares one ready/valid range generator between two requesters.
//
// A requester pulses reqk_start with its argument reqk_n. The argument is
// latched and the requester is marked pending. From IDLE the arbiter grants one
// pending requester, using round-robin when both are waiting. It then pulses
// gen_start for one cycle (LAUNCH). In STREAM it connects the generator's
// ready/valid stream and done pulse to the granted requester until gen_done.
//
// Ports
//   _clock, _reset          clock, asynchronous active-high reset
//   reqk_start, reqk_n      request pulse and its argument (k = 0, 1)
//   reqk_ready              requester k accepts the item on out0/out1
//   reqk_valid, reqk_done   item valid / sequence-complete pulse for requester k
//   reqk_busy               requester k is pending or currently granted
//   out0, out1              shared output bus; wired straight from the generator
//   gen_start, gen_n        generator launch pulse and argument
//   gen_ready               backpressure to the generator
//   gen_valid, gen_done     generator item valid / completion pulse
//   gen_out0, gen_out1      generator output tuple
//
// Handshake: an item transfers on a rising edge where reqk_valid and
// reqk_ready are both high. valid is never withdrawn while waiting for ready.
// In STREAM, gen_ready is the granted requester's ready, so a transfer at the
// requester side is also the same transfer at the generator side.
module hrange_arbiter #(
  parameter int W = 32
) (
  input  logic                _clock,
  input  logic                _reset,
  input  logic                req0_start,
  input  logic                req1_start,
  input  logic signed [W-1:0] req0_n,
  input  logic signed [W-1:0] req1_n,
  input  logic                req0_ready,
  input  logic                req1_ready,
  output logic                req0_valid,
  output logic                req1_valid,
  output logic                req0_done,
  output logic                req1_done,
  output logic                req0_busy,
  output logic                req1_busy,
  output logic signed [W-1:0] out0,
  output logic signed [W-1:0] out1,
  output logic                gen_start,
  output logic signed [W-1:0] gen_n,
  output logic                gen_ready,
  input  logic                gen_valid,
  input  logic                gen_done,
  input  logic signed [W-1:0] gen_out0,
  input  logic signed [W-1:0] gen_out1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t              state, state_next;
  logic                pending0, pending1;
  logic signed [W-1:0] n0, n1;
  logic                grant, grant_next;
  logic                last, last_next;
  logic                take0, take1;
  logic                accept0, accept1;

  // A start is only honoured when the requester has nothing outstanding;
  // otherwise it is dropped and the latched argument is left untouched.
  assign accept0 = req0_start & ~req0_busy;
  assign accept1 = req1_start & ~req1_busy;

  assign req0_busy = pending0 | ((state != IDLE) & ~grant);
  assign req1_busy = pending1 | ((state != IDLE) &  grant);

  assign gen_n = grant ? n1 : n0;
  assign out0  = gen_out0;
  assign out1  = gen_out1;

  always_comb begin
    state_next = state;
    grant_next = grant;
    last_next  = last;
    take0      = 1'b0;
    take1      = 1'b0;
    gen_start  = 1'b0;
    gen_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_done  = 1'b0;
    req1_done  = 1'b0;
    case (state)
      IDLE: begin
        if (pending0 && pending1) begin
          // Round-robin: the requester not served last goes first.
          grant_next = ~last;
          take0      = last;
          take1      = ~last;
          state_next = LAUNCH;
        end else if (pending0) begin
          grant_next = 1'b0;
          take0      = 1'b1;
          state_next = LAUNCH;
        end else if (pending1) begin
          grant_next = 1'b1;
          take1      = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        gen_start  = 1'b1;
        state_next = STREAM;
      end
      STREAM: begin
        if (grant) begin
          gen_ready  = req1_ready;
          req1_valid = gen_valid;
          req1_done  = gen_done;
        end else begin
          gen_ready  = req0_ready;
          req0_valid = gen_valid;
          req0_done  = gen_done;
        end
        if (gen_done) begin
          last_next  = grant;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state    <= IDLE;
      pending0 <= 1'b0;
      pending1 <= 1'b0;
      n0       <= '0;
      n1       <= '0;
      grant    <= 1'b0;
      last     <= 1'b1;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      last     <= last_next;
      // accept and take never coincide for one requester: accept needs the
      // flag clear, take needs it set.
      pending0 <= (pending0 & ~take0) | accept0;
      pending1 <= (pending1 & ~take1) | accept1;
      if (accept0) n0 <= req0_n;
      if (accept1) n1 <= req1_n;
    end
  end

endmodule

// File: tb/tb_hrange_arbiter.sv
module tb_hrange_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_start = 1'b0, req1_start = 1'b0;
  logic signed [W-1:0] req0_n = '0, req1_n = '0;
  logic req0_ready = 1'b1, req1_ready = 1'b1;
  logic req0_valid, req1_valid, req0_done, req1_done, req0_busy, req1_busy;
  logic signed [W-1:0] out0, out1, gen_n, gen_out0, gen_out1;
  logic gen_start, gen_ready, gen_valid, gen_done;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  hrange_arbiter #(.W(W)) dut (
    ._clock(clk), ._reset(rst),
    .req0_start(req0_start), .req1_start(req1_start),
    .req0_n(req0_n), .req1_n(req1_n),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_done(req0_done), .req1_done(req1_done),
    .req0_busy(req0_busy), .req1_busy(req1_busy),
    .out0(out0), .out1(out1),
    .gen_start(gen_start), .gen_n(gen_n), .gen_ready(gen_ready),
    .gen_valid(gen_valid), .gen_done(gen_done),
    .gen_out0(gen_out0), .gen_out1(gen_out1)
  );

  // Range generator stub: emits (i, i) for i = 0 .. n-1, then a done pulse.
  logic g_active;
  logic signed [W-1:0] g_cnt, g_n;
  assign gen_valid = g_active && (g_cnt < g_n);
  assign gen_done  = g_active && !(g_cnt < g_n);
  assign gen_out0  = g_cnt;
  assign gen_out1  = g_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      g_active <= 1'b0;
      g_cnt    <= '0;
      g_n      <= '0;
    end else if (gen_start) begin
      g_active <= 1'b1;
      g_cnt    <= '0;
      g_n      <= gen_n;
    end else if (g_active) begin
      if (gen_done) g_active <= 1'b0;
      else if (gen_valid && gen_ready) g_cnt <= g_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int k, input int n);
    if (k == 0) begin req0_start = 1'b1; req0_n = n; end
    else        begin req1_start = 1'b1; req1_n = n; end
    tick();
    req0_start = 1'b0;
    req1_start = 1'b0;
  endtask

  task automatic start2(input int n0, input int n1);
    req0_start = 1'b1; req0_n = n0;
    req1_start = 1'b1; req1_n = n1;
    tick();
    req0_start = 1'b0;
    req1_start = 1'b0;
  endtask

  task automatic push_range(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(i);
  endtask

  // Runs requester k's sequence to its done pulse, scoring every transfer
  // against exp_q. Returns one cycle after the done edge.
  task automatic serve(input int k, input bit toggle);
    int dones = 0;
    int cyc = 0;
    bit fin = 0;
    logic v, d, ov, od, r;
    logic [W-1:0] e;
    while (!fin && cyc < 60) begin
      if (toggle) begin
        if (k == 0) req0_ready = (cyc % 2 == 0);
        else        req1_ready = (cyc % 2 == 0);
      end
      #1;
      v  = (k == 0) ? req0_valid : req1_valid;
      d  = (k == 0) ? req0_done  : req1_done;
      ov = (k == 0) ? req1_valid : req0_valid;
      od = (k == 0) ? req1_done  : req0_done;
      r  = (k == 0) ? req0_ready : req1_ready;
      check("other_valid", ov, 0);
      check("other_done", od, 0);
      if (v) check("gen_ready_mirror", gen_ready, r);
      if (v && r) begin
        if (exp_q.size() == 0) check("extra_item", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("out0", out0, $signed(e));
          check("out1", out1, $signed(e));
        end
      end
      if (d) begin
        dones++;
        fin = 1;
      end
      tick();
      cyc++;
    end
    check("done_count", dones, 1);
    check("items_left", exp_q.size(), 0);
    check("busy_after_done", (k == 0) ? req0_busy : req1_busy, 0);
    req0_ready = 1'b1;
    req1_ready = 1'b1;
  endtask

  initial begin
    // reset state
    tick();
    check("rst_gen_start", gen_start, 0);
    check("rst_gen_ready", gen_ready, 0);
    check("rst_busy0", req0_busy, 0);
    check("rst_busy1", req1_busy, 0);
    check("rst_valid0", req0_valid, 0);
    check("rst_done1", req1_done, 0);
    check("rst_out0", out0, gen_out0);
    check("rst_gen_n", gen_n, 0);
    #3 rst = 1'b0;
    tick();

    // simultaneous after reset: req0 first, req1 LAUNCH two cycles after done
    start2(2, 1);
    check("sim_busy0", req0_busy, 1);
    check("sim_busy1", req1_busy, 1);
    push_range(2);
    serve(0, 0);
    check("b2b_idle_gen_start", gen_start, 0);
    tick();
    check("b2b_launch_gen_start", gen_start, 1);
    check("b2b_gen_n", gen_n, 1);
    push_range(1);
    serve(1, 0);

    // fairness: three simultaneous rounds give 0,1,0,1,0,1
    for (int round = 0; round < 3; round++) begin
      start2(1, 1);
      push_range(1);
      serve(0, 0);
      push_range(1);
      serve(1, 0);
    end

    // single request with latency check
    start(0, 3);
    check("lat_t1_gen_start", gen_start, 0);
    check("lat_t1_busy0", req0_busy, 1);
    tick();
    check("lat_launch_gen_start", gen_start, 1);
    check("lat_launch_gen_n", gen_n, 3);
    tick();
    check("lat_stream_gen_start", gen_start, 0);
    check("lat_stream_valid0", req0_valid, 1);
    check("lat_stream_out0", out0, 0);
    push_range(3);
    serve(0, 0);

    // last = 0 now, so req1 wins this contention
    start2(1, 2);
    push_range(2);
    serve(1, 0);
    push_range(1);
    serve(0, 0);

    // backpressure on req0
    start(0, 4);
    push_range(4);
    serve(0, 1);

    // zero-length and negative n
    start(0, 0);
    serve(0, 0);
    start(1, -2);
    serve(1, 0);

    // duplicate start while pending is ignored; n0 keeps its first value
    start(0, 2);
    start(0, 7);
    check("dup_gen_start", gen_start, 1);
    check("dup_gen_n", gen_n, 2);
    push_range(2);
    serve(0, 0);
    for (int i = 0; i < 3; i++) begin
      check("dup_no_relaunch", gen_start, 0);
      tick();
    end

    // async reset in the middle of a stream
    start(0, 4);
    tick();
    tick();
    check("ar_valid_before", req0_valid, 1);
    tick();
    #2 rst = 1'b1;
    #1;
    check("ar_busy0", req0_busy, 0);
    check("ar_valid0", req0_valid, 0);
    check("ar_gen_ready", gen_ready, 0);
    check("ar_gen_start", gen_start, 0);
    check("ar_gen_n", gen_n, 0);
    tick();
    check("ar_no_done", req0_done, 0);
    check("ar_busy_held", req0_busy, 0);
    #2 rst = 1'b0;
    tick();
    start2(1, 1);
    push_range(1);
    serve(0, 0);
    tick();
    check("ar_req1_launch", gen_start, 1);
    push_range(1);
    serve(1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
